// File: rtl/cla_multiword_sequencer.sv
// cla_multiword_sequencer: WIDTH-bit adder that reuses one 4-bit CLA slice,
// one nibble per clock (LSB first), with valid/ready on input and output.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/a/b/cin in;
// out_valid/out_ready/sum/cout out; busy; ovf only with CLA_SEQ_OVF_EN.
module cla_multiword_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  // partial-sum register holds the nibbles finished so far
  localparam int SW = (WIDTH > 4) ? WIDTH - 4 : 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_chk
    $error("WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, nstate;

  logic [WIDTH-1:0] ar, br, sum_q;
  logic [SW-1:0]    sr;
  logic [SW+3:0]    cat;
  logic [CW-1:0]    cnt;
  logic             cr, cout_q, rdy_q;
  logic [3:0]       g, p, s;
  logic             c1, c2, c3, c4;
  logic             accept, last;

  assign accept = (state == IDLE) & rdy_q & in_valid;
  assign last   = (cnt == CW'(NSLICE - 1));

  // 4-bit look-ahead slice on the low nibbles
  assign g  = ar[3:0] & br[3:0];
  assign p  = ar[3:0] ^ br[3:0];
  assign c1 = g[0] | (p[0] & cr);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cr);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cr);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cr);
  assign s  = p ^ {c3, c2, c1, cr};

  // new nibble enters at the top; on the last slice this is the full sum
  assign cat = {s, sr};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (accept)    nstate = RUN;
      RUN:     if (last)      nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  // registered so in_ready stays low through reset and the first
  // cycle out of it, and never follows in_valid/out_ready directly
  always_ff @(posedge clk) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= (nstate == IDLE);
  end

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar     <= '0;
      br     <= '0;
      sr     <= '0;
      cr     <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      ar  <= a;
      br  <= b;
      cr  <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      ar  <= ar >> 4;
      br  <= br >> 4;
      sr  <= cat[SW+3:4];
      cr  <= c4;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum_q  <= cat[SW+3 -: WIDTH];
        cout_q <= c4;
`ifdef CLA_SEQ_OVF_EN
        ovf_q  <= c3 ^ c4;
`endif
      end
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// tb_cla_multiword_sequencer: scoreboard bench for the nibble-serial
// CLA sequencer at WIDTH=16 (ovf checks when CLA_SEQ_OVF_EN is defined).
module tb_cla_multiword_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  res_t q[$];
  int   pass_n = 0;
  int   total_n = 0;

  cla_multiword_sequencer #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .busy(busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci);
    logic [W:0] t;
    res_t r;
    t = {1'b0, x} + {1'b0, y} + (W + 1)'(ci);
    r.s = t[W-1:0];
    r.c = t[W];
    r.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // present operands until accepted; accept lands on the next posedge
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input bit push, output bit ok);
    int n = 0;
    @(negedge clk);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (push) q.push_back(model(x, y, ci));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic take(output res_t got);
    got.s = sum;
    got.c = cout;
`ifdef CLA_SEQ_OVF_EN
    got.v = ovf;
`else
    got.v = 1'b0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_n++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_n++;
    total_n++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_n++;
    total_n++; if (sum !== 16'h0000) $display("FAIL rst_sum got %h want 0000", sum); else pass_n++;
    total_n++; if (cout !== 1'b0) $display("FAIL rst_cout got %b want 0", cout); else pass_n++;
`ifdef CLA_SEQ_OVF_EN
    total_n++; if (ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", ovf); else pass_n++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    total_n++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else pass_n++;
  endtask

  task automatic test_basic();
    logic [32:0] vecs [3];
    logic [32:0] v;
    res_t exp, got;
    bit ok;
    int cyc;
    vecs[0] = {16'h00FF, 16'h0001, 1'b0};
    vecs[1] = {16'hFFFF, 16'h0001, 1'b0};
    vecs[2] = {16'hFFFF, 16'h0000, 1'b1};
    for (int i = 0; i < 3; i++) begin
      v = vecs[i];
      drive_op(v[32:17], v[16:1], v[0], 1'b1, ok);
      total_n++; if (!ok) $display("FAIL basic%0d_accept got timeout want accept", i); else pass_n++;
      total_n++; if (busy !== 1'b1) $display("FAIL basic%0d_busy got %b want 1", i, busy); else pass_n++;
      wait_out(cyc);
      total_n++; if (cyc != 4) $display("FAIL basic%0d_latency got %0d want 4", i, cyc); else pass_n++;
      take(got);
      exp = q.pop_front();
      total_n++; if (got.s !== exp.s) $display("FAIL basic%0d_sum got %h want %h", i, got.s, exp.s); else pass_n++;
      total_n++; if (got.c !== exp.c) $display("FAIL basic%0d_cout got %b want %b", i, got.c, exp.c); else pass_n++;
    end
  endtask

  task automatic test_stall();
    res_t exp, got;
    bit ok;
    int cyc;
    drive_op(16'h1234, 16'h4321, 1'b0, 1'b1, ok);
    total_n++; if (!ok) $display("FAIL stall_accept got timeout want accept"); else pass_n++;
    wait_out(cyc);
    total_n++; if (cyc != 4) $display("FAIL stall_latency got %0d want 4", cyc); else pass_n++;
    for (int i = 0; i < 10; i++) begin
      total_n++; if (out_valid !== 1'b1) $display("FAIL stall%0d_valid got %b want 1", i, out_valid); else pass_n++;
      total_n++; if (sum !== 16'h5555) $display("FAIL stall%0d_sum got %h want 5555", i, sum); else pass_n++;
      total_n++; if (in_ready !== 1'b0) $display("FAIL stall%0d_ready got %b want 0", i, in_ready); else pass_n++;
      in_valid = (i % 2 == 0);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    take(got);
    exp = q.pop_front();
    total_n++; if (got.s !== exp.s) $display("FAIL stall_sum got %h want %h", got.s, exp.s); else pass_n++;
    total_n++; if (got.c !== exp.c) $display("FAIL stall_cout got %b want %b", got.c, exp.c); else pass_n++;
    total_n++; if (in_ready !== 1'b1) $display("FAIL stall_ready_after got %b want 1", in_ready); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL stall_busy_after got %b want 0", busy); else pass_n++;
  endtask

  task automatic test_reset_mid();
    res_t exp, got;
    bit ok;
    int cyc;
    drive_op(16'h0005, 16'h0003, 1'b0, 1'b0, ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_n++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_n++;
    total_n++; if (sum !== 16'h0000) $display("FAIL midrst_sum got %h want 0000", sum); else pass_n++;
    total_n++; if (in_ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", in_ready); else pass_n++;
    rst_n = 1'b1;
    @(negedge clk);
    total_n++; if (in_ready !== 1'b1) $display("FAIL midrst_ready_back got %b want 1", in_ready); else pass_n++;
    drive_op(16'h000C, 16'h0009, 1'b0, 1'b1, ok);
    wait_out(cyc);
    total_n++; if (cyc != 4) $display("FAIL midrst_latency got %0d want 4", cyc); else pass_n++;
    take(got);
    exp = q.pop_front();
    total_n++; if (got.s !== exp.s) $display("FAIL midrst_sum2 got %h want %h", got.s, exp.s); else pass_n++;
  endtask

  task automatic test_back_to_back();
    res_t exp;
    int t = 0;
    int t0, t1;
    int n = 0;
    @(negedge clk);
    a = 16'd2; b = 16'd15; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    t0 = t;
    q.push_back(model(16'd2, 16'd15, 1'b0));
    @(negedge clk); t++;
    a = 16'd13; b = 16'd13;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk); t++;
      n++;
    end
    exp = q.pop_front();
    total_n++; if (sum !== exp.s) $display("FAIL b2b_sum0 got %h want %h", sum, exp.s); else pass_n++;
    @(negedge clk); t++;
    total_n++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", in_ready); else pass_n++;
    t1 = t;
    q.push_back(model(16'd13, 16'd13, 1'b0));
    total_n++; if (t1 - t0 != 6) $display("FAIL b2b_spacing got %0d want 6", t1 - t0); else pass_n++;
    @(negedge clk); t++;
    in_valid = 1'b0;
    total_n++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else pass_n++;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp = q.pop_front();
    total_n++; if (out_valid !== 1'b1) $display("FAIL b2b_valid1 got %b want 1", out_valid); else pass_n++;
    total_n++; if (sum !== exp.s) $display("FAIL b2b_sum1 got %h want %h", sum, exp.s); else pass_n++;
    @(negedge clk);
    out_ready = 1'b0;
    total_n++; if (out_valid !== 1'b0) $display("FAIL b2b_drained got %b want 0", out_valid); else pass_n++;
  endtask

`ifdef CLA_SEQ_OVF_EN
  task automatic test_ovf();
    logic [31:0] vecs [2];
    res_t exp, got;
    bit ok;
    int cyc;
    vecs[0] = {16'h7FFF, 16'h0001};
    vecs[1] = {16'h8000, 16'h8000};
    for (int i = 0; i < 2; i++) begin
      drive_op(vecs[i][31:16], vecs[i][15:0], 1'b0, 1'b1, ok);
      wait_out(cyc);
      take(got);
      exp = q.pop_front();
      total_n++; if (got.s !== exp.s) $display("FAIL ovf%0d_sum got %h want %h", i, got.s, exp.s); else pass_n++;
      total_n++; if (got.c !== exp.c) $display("FAIL ovf%0d_cout got %b want %b", i, got.c, exp.c); else pass_n++;
      total_n++; if (got.v !== exp.v) $display("FAIL ovf%0d_ovf got %b want %b", i, got.v, exp.v); else pass_n++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef CLA_SEQ_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
